// File: rtl/aes_uart_sequencer.sv
// Job controller: launches one AES-128 encryption under a watchdog, then
// streams the ciphertext to a UART byte interface as hex ASCII + CR LF or raw bytes.
module aes_uart_sequencer #(
  parameter bit          HEX_ASCII      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [127:0] i_plain,
  input  logic [127:0] i_key,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [127:0] o_cipher,
  output logic         o_aes_start,
  output logic [127:0] o_aes_plain,
  output logic [127:0] o_aes_key,
  input  logic         i_aes_done,
  input  logic [127:0] i_aes_cipher,
  output logic         o_tx_valid,
  output logic [7:0]   o_tx_byte,
  input  logic         i_tx_ready
);

  localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]  LAST_IDX = HEX_ASCII ? 6'd33 : 6'd15;

  typedef enum logic [2:0] {IDLE, START, WAIT, SEND, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  wcnt;
  logic [127:0]   shreg;
  logic [5:0]     idx;
  logic [3:0]     nib;
  logic [7:0]     tx_char;
  logic           accept;
  logic           timeout;

  assign accept  = o_tx_valid && i_tx_ready;
  assign timeout = (wcnt == CW'(TIMEOUT_CYCLES - 1));
  assign nib     = shreg[127:124];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (i_aes_done) state_nx = SEND;
               else if (timeout) state_nx = IDLE;
      SEND:    if (accept && (idx == LAST_IDX)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Status outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_aes_start <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_cipher    <= '0;
      o_aes_plain <= '0;
      o_aes_key   <= '0;
      shreg       <= '0;
      idx         <= '0;
      wcnt        <= '0;
    end else begin
      o_busy      <= (state_nx != IDLE);
      o_aes_start <= (state_nx == START);
      o_tx_valid  <= (state_nx == SEND);
      o_done      <= (state_nx == DONE);
      case (state)
        IDLE: if (i_start) begin
          o_aes_plain <= i_plain;
          o_aes_key   <= i_key;
          o_error     <= 1'b0;
        end
        START: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + CW'(1);
          if (i_aes_done) begin
            o_cipher <= i_aes_cipher;
            shreg    <= i_aes_cipher;
            idx      <= '0;
          end else if (timeout) begin
            o_error <= 1'b1;
          end
        end
        SEND: if (accept) begin
          idx <= idx + 6'd1;
          if (HEX_ASCII) shreg <= {shreg[123:0], 4'h0};
          else           shreg <= {shreg[119:0], 8'h00};
        end
        default: ;
      endcase
    end
  end

  // Current char is always at the top of the shift register; CR LF follow the 32 nibbles.
  always_comb begin
    tx_char = '0;
    if (HEX_ASCII) begin
      if (idx == 6'd32)      tx_char = 8'h0D;
      else if (idx == 6'd33) tx_char = 8'h0A;
      else if (nib < 4'd10)  tx_char = {4'h3, nib};
      else                   tx_char = 8'h37 + {4'h0, nib};
    end else begin
      tx_char = shreg[127:120];
    end
    o_tx_byte = o_tx_valid ? tx_char : '0;
  end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Scoreboard bench for aes_uart_sequencer: a hex-mode and a raw-mode instance share
// the core/UART stimulus; monitors pop expected chars on every handshake.
module tb_aes_uart_sequencer;

  localparam logic [127:0] PLAIN = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT2   = 128'h00112233445566778899aabbccddeeff;

  logic clk, rst_n, start_hex, start_raw, aes_done, tx_ready;
  logic [127:0] plain, key, aes_cipher;

  logic h_busy, h_done, h_error, h_aes_start, h_tx_valid;
  logic [127:0] h_cipher, h_aes_plain, h_aes_key;
  logic [7:0] h_tx_byte;
  logic r_busy, r_done, r_error, r_aes_start, r_tx_valid;
  logic [127:0] r_cipher, r_aes_plain, r_aes_key;
  logic [7:0] r_tx_byte;

  int n_tests = 0, n_fail = 0;
  int st_hex = 0, st_raw = 0, dn_hex = 0, dn_raw = 0, acc_hex = 0;
  bit bp = 0;
  logic [7:0] sb_hex[$], sb_raw[$];
  bit stall_h = 0, stall_r = 0;
  logic [7:0] hold_h, hold_r;

  aes_uart_sequencer #(.HEX_ASCII(1'b1), .TIMEOUT_CYCLES(64)) dut_hex (
    .clk(clk), .rst_n(rst_n), .i_start(start_hex), .i_plain(plain), .i_key(key),
    .o_busy(h_busy), .o_done(h_done), .o_error(h_error), .o_cipher(h_cipher),
    .o_aes_start(h_aes_start), .o_aes_plain(h_aes_plain), .o_aes_key(h_aes_key),
    .i_aes_done(aes_done), .i_aes_cipher(aes_cipher),
    .o_tx_valid(h_tx_valid), .o_tx_byte(h_tx_byte), .i_tx_ready(tx_ready));

  aes_uart_sequencer #(.HEX_ASCII(1'b0), .TIMEOUT_CYCLES(64)) dut_raw (
    .clk(clk), .rst_n(rst_n), .i_start(start_raw), .i_plain(plain), .i_key(key),
    .o_busy(r_busy), .o_done(r_done), .o_error(r_error), .o_cipher(r_cipher),
    .o_aes_start(r_aes_start), .o_aes_plain(r_aes_plain), .o_aes_key(r_aes_key),
    .i_aes_done(aes_done), .i_aes_cipher(aes_cipher),
    .o_tx_valid(r_tx_valid), .o_tx_byte(r_tx_byte), .i_tx_ready(tx_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // UART ready: held high, or pseudo-random when backpressure is enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_h = 0;
    end else begin
      if (h_tx_valid) begin
        if (stall_h) chk("hex hold", h_tx_byte, hold_h);
        if (tx_ready) begin
          if (sb_hex.size() == 0) chk("hex extra char", h_tx_byte, 8'hxx);
          else chk("hex char", h_tx_byte, sb_hex.pop_front());
          acc_hex++;
          stall_h = 0;
        end else begin
          stall_h = 1;
          hold_h  = h_tx_byte;
        end
      end else stall_h = 0;
      if (h_aes_start) st_hex++;
      if (h_done) dn_hex++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_r = 0;
    end else begin
      if (r_tx_valid) begin
        if (stall_r) chk("raw hold", r_tx_byte, hold_r);
        if (tx_ready) begin
          if (sb_raw.size() == 0) chk("raw extra char", r_tx_byte, 8'hxx);
          else chk("raw char", r_tx_byte, sb_raw.pop_front());
          stall_r = 0;
        end else begin
          stall_r = 1;
          hold_r  = r_tx_byte;
        end
      end else stall_r = 0;
      if (r_aes_start) st_raw++;
      if (r_done) dn_raw++;
    end
  end

  task automatic push_hex(input string s);
    for (int i = 0; i < 32; i++) sb_hex.push_back(s[i]);
    sb_hex.push_back(8'h0D);
    sb_hex.push_back(8'h0A);
  endtask

  task automatic job(input bit raw, input logic [127:0] c, input string s, input int lat, input bit ign);
    int n, st0, dn0;
    bit seen;
    st0 = raw ? st_raw : st_hex;
    dn0 = raw ? dn_raw : dn_hex;
    if (raw) for (int i = 0; i < 16; i++) sb_raw.push_back(c[127-8*i -: 8]);
    else push_hex(s);
    @(posedge clk); #1;
    if (raw) start_raw = 1'b1; else start_hex = 1'b1;
    @(posedge clk); #1;
    start_raw = 1'b0; start_hex = 1'b0;
    chk("aes_start in START", raw ? r_aes_start : h_aes_start, 1);
    chk("busy in START", raw ? r_busy : h_busy, 1);
    chk("error cleared", raw ? r_error : h_error, 0);
    chk("aes_plain", raw ? r_aes_plain : h_aes_plain, PLAIN);
    chk("aes_key", raw ? r_aes_key : h_aes_key, KEY);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      start_hex = ign && (i == 0);
    end
    start_hex = 1'b0;
    aes_done = 1'b1; aes_cipher = c;
    @(posedge clk); #1;
    aes_done = 1'b0; aes_cipher = '0;
    chk("cipher latched", raw ? r_cipher : h_cipher, c);
    chk("valid after done", raw ? r_tx_valid : h_tx_valid, 1);
    if (ign) begin
      start_hex = 1'b1; aes_done = 1'b1; aes_cipher = ~c;
      @(posedge clk); #1;
      start_hex = 1'b0; aes_done = 1'b0; aes_cipher = '0;
    end
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = raw ? r_done : h_done;
    end
    chk("done pulse seen", seen, 1);
    if (!bp && !ign) chk("stream cycles", n, (raw ? 16 : 34) + 1);
    if (ign && seen) begin
      start_hex = 1'b1;
      @(posedge clk); #1;
      start_hex = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle after job", raw ? r_busy : h_busy, 0);
    chk("all chars sent", raw ? sb_raw.size() : sb_hex.size(), 0);
    chk("one aes_start", (raw ? st_raw : st_hex) - st0, 1);
    chk("one done", (raw ? dn_raw : dn_hex) - dn0, 1);
    chk("cipher held", raw ? r_cipher : h_cipher, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: sim time %0t exceeded", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, acc0, dn0;
    bit txseen;
    rst_n = 1'b0; start_hex = 1'b0; start_raw = 1'b0; aes_done = 1'b0;
    aes_cipher = '0; plain = PLAIN; key = KEY;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hex ctl", {h_busy, h_done, h_error, h_aes_start, h_tx_valid, h_tx_byte}, 0);
    chk("reset hex data", h_cipher | h_aes_plain | h_aes_key, 0);
    chk("reset raw ctl", {r_busy, r_done, r_error, r_aes_start, r_tx_valid, r_tx_byte}, 0);
    rst_n = 1'b1;

    job(1'b0, CT1, "3925841D02DC09FBDC118597196A0B32", 5, 1'b0);
    job(1'b1, CT1, "", 3, 1'b0);
    bp = 1;
    job(1'b0, CT2, "00112233445566778899AABBCCDDEEFF", 7, 1'b0);
    bp = 0;
    repeat (2) @(posedge clk);

    // Watchdog: core never answers.
    dn0 = dn_hex;
    @(posedge clk); #1; start_hex = 1'b1;
    @(posedge clk); #1; start_hex = 1'b0;
    n = 0; txseen = 0;
    while (!h_error && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (h_tx_valid) txseen = 1;
    end
    chk("watchdog edges", n, 65);
    chk("watchdog no tx", txseen, 0);
    chk("watchdog not busy", h_busy, 0);
    chk("watchdog cipher kept", h_cipher, CT2);
    repeat (3) @(posedge clk);
    #1;
    chk("error sticky", h_error, 1);
    chk("watchdog no done", dn_hex - dn0, 0);

    job(1'b0, CT1, "3925841D02DC09FBDC118597196A0B32", 4, 1'b1);

    // Reset in the middle of a hex stream.
    push_hex("3925841D02DC09FBDC118597196A0B32");
    acc0 = acc_hex;
    @(posedge clk); #1; start_hex = 1'b1;
    @(posedge clk); #1; start_hex = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    aes_done = 1'b1; aes_cipher = CT1;
    @(posedge clk); #1;
    aes_done = 1'b0; aes_cipher = '0;
    n = 0;
    while (acc_hex < acc0 + 10 && n < 200) begin @(negedge clk); n++; end
    chk("ten chars before reset", acc_hex - acc0, 10);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ctl", {h_busy, h_done, h_error, h_aes_start, h_tx_valid, h_tx_byte}, 0);
    chk("async reset data", h_cipher | h_aes_plain | h_aes_key, 0);
    chk("async reset raw cipher", r_cipher, 0);
    sb_hex.delete();
    #20;
    rst_n = 1'b1;
    job(1'b0, CT1, "3925841D02DC09FBDC118597196A0B32", 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_uart_sequencer.md
# aes_uart_sequencer

Job controller between the iterative AES-128 core and the UART transmitter in the FPGA top level. On a start request it captures plaintext and key, launches one encryption, and waits for completion under a watchdog. It then latches the ciphertext and streams it to the UART byte interface, either as ASCII hex terminated by CR LF or as 16 raw bytes.

## Interface
- HEX_ASCII, 1, 1: send 32 uppercase hex chars + 0x0D 0x0A (34 chars); 0: send 16 raw bytes.
- TIMEOUT_CYCLES, 64, max WAIT-state cycles allowed for `i_aes_done`; legal range ≥ 2.

- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  job request, sampled in IDLE only.
- i_plain  in  128  plaintext; bits [127:120] are byte 0.
- i_key  in  128  key, same byte order.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the last char is accepted.
- o_error  out  1  sticky watchdog flag; cleared by the next accepted `i_start`.
- o_cipher  out  128  last completed ciphertext; holds until the next completion.
- o_aes_start  out  1  one-cycle launch pulse to the core.
- o_aes_plain  out  128  captured plaintext; stable from START until the next accepted start.
- o_aes_key  out  128  captured key; same stability rule.
- i_aes_done  in  1  core completion pulse; ignored outside WAIT.
- i_aes_cipher  in  128  core result, valid while `i_aes_done` is high.
- o_tx_valid  out  1  char available to the UART.
- o_tx_byte  out  8  char to send.
- i_tx_ready  in  1  UART accepts the char when `o_tx_valid` and `i_tx_ready` are both high at a clock edge.

## Operation
- **States:** IDLE, START, WAIT, SEND, DONE.
- **IDLE:**
  - On `i_start`=1: capture `i_plain` and `i_key`, clear `o_error`, go to START.
- **START:**
  - `o_aes_start`=1 for exactly this cycle.
  - Clear the watchdog counter, go to WAIT.
- **WAIT:**
  - Counter width is clog2(TIMEOUT_CYCLES+1); it increments once per WAIT cycle.
  - If `i_aes_done`=1: latch `i_aes_cipher` into `o_cipher` and into a send shift register, clear the char index, go to SEND.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: set `o_error`=1, go to IDLE. No chars are sent, `o_done` does not pulse, and `o_cipher` is unchanged.
  - If done and timeout coincide, done wins.
- **SEND:**
  - `o_tx_valid`=1 throughout.
  - `o_tx_byte` stays stable until accepted; it never changes while valid is high and ready is low.
  - HEX_ASCII=1: chars are sent high nibble first for byte 0..15. Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46. Chars 33 and 34 are 0x0D and 0x0A.
  - HEX_ASCII=0: bytes 0..15 are sent raw.
  - Each handshake advances the index. After the last char is accepted, go to DONE.
- **DONE:**
  - `o_done`=1 for this cycle, then go to IDLE.
- **Ignored inputs:**
  - `i_start` outside IDLE, including the DONE cycle.
  - `i_aes_done` outside WAIT.
- **Reset:**
  - Asserting `rst_n`=0 at any point forces IDLE immediately.
  - All outputs go to 0: `o_busy`, `o_done`, `o_error`, `o_aes_start`, `o_tx_valid`, `o_tx_byte`, `o_cipher`, `o_aes_plain`, `o_aes_key`.
  - Reset during SEND drops `o_tx_valid` asynchronously, and the partial transmission is abandoned.

## Timing
- Edge 0 samples `i_start`.
- Cycle 1: START, `o_aes_start`=1, `o_busy`=1.
- Cycles 2+: WAIT.
- `i_aes_done` sampled at edge k:
  - `o_cipher` updates after edge k.
  - `o_tx_valid`=1 in cycle k+1.
- With `i_tx_ready` held high, one char is sent per cycle: 34 cycles (HEX_ASCII=1) or 16 cycles (HEX_ASCII=0).
  - `o_done` pulses the cycle after the final acceptance.
  - IDLE follows the next cycle.
- Minimum start-to-start spacing with ready held high: 1 + 1 + W + N + 1 cycles, where W = WAIT cycles and N = char count.
- Timeout: with no done, `o_error` rises and the block returns to IDLE after exactly TIMEOUT_CYCLES WAIT cycles.
- All outputs are registered except `o_tx_byte`, which may be decoded combinationally from the registered index and shift register.

## Test plan
- **FIPS-197 vector, hex mode:**
  - Stimulus: plain 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, core model returns 3925841d02dc09fbdc118597196a0b32, ready held high.
  - Required: exactly one `o_aes_start` pulse; chars 0x33 0x39 0x32 0x35 … 0x33 0x32 0x0D 0x0A (34 total); `o_cipher` equals the ciphertext; one `o_done` pulse.
- **Raw mode (HEX_ASCII=0):** same vector -> 16 bytes 0x39, 0x25, 0x84 … 0x0B, 0x32, then `o_done`.
- **UART backpressure:** toggle `i_tx_ready` pseudo-randomly -> `o_tx_byte` never changes while valid is high and ready is low; no char is lost or duplicated.
- **Watchdog:** core never returns done, TIMEOUT_CYCLES=64 -> `o_error`=1 after 64 WAIT cycles; `o_tx_valid` never rises; `o_busy`=0 afterwards; the next `i_start` clears `o_error`.
- **Ignored events:**
  - Stimulus: `i_start` pulsed during WAIT, SEND and DONE, plus a spurious `i_aes_done` in SEND.
  - Required: still one job, one `o_aes_start` pulse, and an unchanged char stream.
- **Reset mid-SEND:** assert `rst_n`=0 after the 10th char -> all outputs are 0 asynchronously; after release, a new `i_start` produces a full, correct 34-char stream.
